psum_out_serializer: RTL and testbench
======================================

# psum_out_serializer

Downstream consumer of the core's `coreOut` output. It accepts one full psum row of `col` × `psum_bw` bits per handshake and buffers it in a small FIFO. It then streams the row out one `psum_bw` element per cycle over a valid/ready interface, optionally applying ReLU. It decouples the core's row-burst output from a narrow host/readout port.

## Interface
Parameters:
- `col`, 8, number of psum elements per input row
- `psum_bw`, 16, width of one signed psum element
- `depth`, 4, input FIFO depth in rows; power of two, ≥ 2

Ports:
- `clk`  input  1  single clock; all logic on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  `in_data` holds a row (driven from the core's `valid`)
- `in_data`  input  psum_bw*col  row; element c is bits [psum_bw*(c+1)-1 : psum_bw*c]
- `in_ready`  output  1  block can accept a row this cycle
- `out_valid`  output  1  `out_data` holds an element
- `out_ready`  input  1  sink accepts the element
- `out_data`  output  psum_bw  current element (signed, two's complement)
- `out_col`  output  $clog2(col)  column index of `out_data`
- `out_last`  output  1  `out_data` is column col-1 of its row
- `row_count`  output  16  rows fully emitted since reset; wraps at 2^16

## Operation
- **Push:**
  - A row is accepted at any edge where `in_valid && in_ready`.
  - `in_ready = !full && !reset`, combinational from registered FIFO occupancy.
  - While full, `in_ready` stays 0 even if the serializer pops that same edge. There is no push-through-full.
- **FIFO:**
  - `depth` entries with read/write pointers of $clog2(depth) bits that wrap modulo `depth`.
  - Occupancy counter is $clog2(depth)+1 bits.
  - full = (occupancy == depth); empty = (occupancy == 0).
  - Simultaneous push and pop leaves occupancy unchanged.
- **Serializer:** a holding register for the current row plus a column counter, driven by a two-state FSM.
  - **IDLE:**
    - `out_valid` = 0.
    - If the FIFO is non-empty at an edge, pop the head into the holding register, set col = 0, and go to STREAM.
  - **STREAM:**
    - `out_valid` = 1; `out_data` = element[col] (after ReLU if enabled); `out_col` = col; `out_last` = (col == col-1).
    - Handshake when `out_valid && out_ready` and not last: col increments.
    - Handshake on the last element: `row_count` increments. Then:
      - If the FIFO is non-empty, load the next head in the same edge, set col = 0, and stay in STREAM.
      - Otherwise go to IDLE.
    - With `out_ready` = 0, all of `out_data`, `out_col` and `out_last` stay stable.
- **Order:** rows leave in acceptance order; columns leave 0 → col-1.
- **Reset mid-operation:** FIFO contents and the holding register are discarded. The pointers, occupancy, col and `row_count` are cleared, and the FSM goes to IDLE.

## Timing
- **Reset values:**
  - `in_ready` = 0 while `reset` is high, and 1 in the first cycle after reset is released.
  - `out_valid` = 0; `out_data` = 0; `out_col` = 0; `out_last` = 0; `row_count` = 0.
- **Latency:** for a row accepted at edge k into an empty FIFO with the serializer IDLE, `out_valid` rises after edge k+1, with column 0 presented.
- **Throughput:**
  - One element per cycle when `out_ready` is held at 1.
  - One row per `col` cycles with no bubble between rows when the FIFO is non-empty.
- **Input acceptance:** a sustained input of one row per cycle is accepted for depth+1 cycles: `depth` FIFO entries plus one popped into the holding register. After that, `in_ready` follows pops.
- **Output registration:** all outputs except `in_ready` are registered or decoded from registered state. There is no combinational path from `out_ready` to `out_valid` or `out_data`.

## Configuration
- `PSUM_OUT_RELU_EN`:
  - When defined, any element whose MSB is 1 is output as 0. Non-negative elements pass unchanged. ReLU is applied on the output path, so the FIFO stores raw values.
  - When undefined, elements pass through bit-exact.
- Neither the timing nor the interface changes with this macro.

## Test plan
- **Single row:** push row elements c = 16'h0010+c at edge 1, with `out_ready` = 1.
  - `out_valid` rises after edge 2.
  - Outputs are 0x0010..0x0017 on 8 consecutive cycles, with `out_last` on 0x0017.
  - `row_count` = 1.
- **Backpressure:** push 5 rows back-to-back with `out_ready` = 0.
  - Rows 1–5 are accepted.
  - `in_ready` = 0 on the 6th cycle.
  - Releasing `out_ready` drains 40 elements in order with no gaps, ending with `row_count` = 5.
- **Stall stability:** toggle `out_ready` pseudo-randomly.
  - `out_data`, `out_col` and `out_last` never change while `out_valid && !out_ready`.
  - No element is dropped or duplicated; check against a scoreboard.
- **ReLU:** push a row of {0x8000, 0xFFFF, 0x0000, 0x7FFF, 0x0001, 0xFFFE, 0x1234, 0x8001}.
  - With `PSUM_OUT_RELU_EN`: 0, 0, 0, 0x7FFF, 1, 0, 0x1234, 0.
  - Without it: identical to the input.
- **Reset mid-row:** assert `reset` for one cycle during column 3 of the first of 2 queued rows.
  - `out_valid` = 0 and `row_count` = 0 after that edge.
  - No remnants of either row are emitted afterwards.
  - A new row pushed after reset is emitted correctly.
- **Counter wrap and pointer wrap:** preload `row_count` via a long run of 65537 single-element-ready rows with `col` = 2.
  - `row_count` reads 1.
  - FIFO pointers wrap repeatedly with no data corruption.

Source files
------------

// File: rtl/psum_out_serializer.sv
// Row-to-element serializer for the core's psum output: a depth-row FIFO feeding a
// holding register streamed one element per cycle. Optional ReLU via PSUM_OUT_RELU_EN.
module psum_out_serializer #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [psum_bw*col-1:0]   in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [psum_bw-1:0]       out_data,
  output logic [$clog2(col)-1:0]   out_col,
  output logic                     out_last,
  output logic [15:0]              row_count
);
  localparam int CW = $clog2(col);
  localparam int PW = $clog2(depth);
  localparam int OW = PW + 1;

  typedef logic [col-1:0][psum_bw-1:0] row_t;
  typedef enum logic {IDLE, STREAM} state_t;

  row_t            mem [depth];
  row_t            hold;
  logic [PW-1:0]   wptr, rptr;
  logic [OW-1:0]   occ;
  logic [CW-1:0]   col_idx;
  state_t          state, state_nx;
  logic            full, empty, push, pop, last, fire;
  logic [psum_bw-1:0] elem;

  assign full     = (occ == OW'(depth));
  assign empty    = (occ == '0);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign last     = (state == STREAM) && (col_idx == CW'(col - 1));
  assign fire     = (state == STREAM) && out_ready;

  // Pop either from IDLE or on the last handshake, so rows chain without a bubble.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop      = 1'b1;
        state_nx = STREAM;
      end
      STREAM: if (fire && last) begin
        if (!empty) pop = 1'b1;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Storage carries no reset; pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      col_idx   <= '0;
      hold      <= '0;
      row_count <= '0;
    end else begin
      state <= state_nx;
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr    <= rptr + PW'(1);
        hold    <= mem[rptr];
        col_idx <= '0;
      end else if (fire && !last) begin
        col_idx <= col_idx + CW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (fire && last) row_count <= row_count + 16'd1;
    end
  end

  assign elem = hold[col_idx];

`ifdef PSUM_OUT_RELU_EN
  assign out_data = elem[psum_bw-1] ? '0 : elem;
`else
  assign out_data = elem;
`endif

  assign out_valid = (state == STREAM);
  assign out_col   = col_idx;
  assign out_last  = last;

endmodule

// File: tb/tb_psum_out_serializer.sv
// Bench for psum_out_serializer: constant vector table, hand sequences for backpressure
// and mid-row reset, then random traffic against a queue-based element model.
module tb_psum_out_serializer;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 4;

  typedef logic [BW-1:0] elem_t;
  typedef logic [COL-1:0][BW-1:0] row_t;
  typedef struct {
    row_t din;
    row_t dout;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [BW*COL-1:0]    in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [BW-1:0]        out_data;
  logic [$clog2(COL)-1:0] out_col;
  logic                 out_last;
  logic [15:0]          row_count;

  psum_out_serializer #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_col(out_col), .out_last(out_last),
    .row_count(row_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: flat queue of expected elements plus column position and row tally.
  elem_t       exp_q[$];
  int          m_col = 0;
  logic [15:0] m_rows = '0;

  function automatic elem_t relu_m(input elem_t e);
`ifdef PSUM_OUT_RELU_EN
    return ($signed(e) < 0) ? elem_t'(0) : e;
`else
    return e;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock: score handshakes seen before the edge, then check post-edge state.
  task automatic cycle();
    logic          push, hs, stalled, rst_was;
    logic [BW-1:0] s_data;
    logic [31:0]   s_col;
    logic          s_last;
    elem_t         e;
    rst_was = reset;
    push    = in_valid && in_ready;
    hs      = out_valid && out_ready;
    stalled = out_valid && !out_ready && !reset;
    s_data  = out_data;
    s_col   = 32'(out_col);
    s_last  = out_last;
    if (!reset) begin
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_data), 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", 32'(out_data), 32'(e));
          chk("m_col", 32'(out_col), 32'(m_col));
          chk("m_last", 32'(out_last), 32'(m_col == COL - 1));
          if (m_col == COL - 1) begin
            m_col  = 0;
            m_rows = m_rows + 16'd1;
          end else begin
            m_col++;
          end
        end
      end
      if (push)
        for (int c = 0; c < COL; c++) exp_q.push_back(relu_m(in_data[c*BW +: BW]));
    end
    @(posedge clk);
    #1;
    if (rst_was) begin
      exp_q.delete();
      m_col  = 0;
      m_rows = '0;
    end
    if (stalled) begin
      chk("stall_data", 32'(out_data), 32'(s_data));
      chk("stall_col", 32'(out_col), s_col);
      chk("stall_last", 32'(out_last), 32'(s_last));
    end
    chk("row_count_m", 32'(row_count), 32'(m_rows));
  endtask

  vec_t vec[4];
  row_t r;
  logic [15:0] ex_rows;
  bit found;

  initial begin
    // vector table: incrementing, ReLU mix, all-ones, alternating sign
    for (int c = 0; c < COL; c++) begin
      vec[0].din[c]  = 16'h0010 + 16'(c);
      vec[0].dout[c] = 16'h0010 + 16'(c);
    end
    vec[1].din = {16'h8001, 16'h1234, 16'hFFFE, 16'h0001, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
`ifdef PSUM_OUT_RELU_EN
    vec[1].dout = {16'h0000, 16'h1234, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    vec[2].dout = '0;
    vec[3].dout = {16'h0000, 16'h0007, 16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'h0000, 16'h0001};
`else
    vec[1].dout = vec[1].din;
    vec[2].dout = {COL{16'hFFFF}};
    vec[3].dout = {16'hFFF8, 16'h0007, 16'hFFFA, 16'h0005, 16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};
`endif
    vec[2].din = {COL{16'hFFFF}};
    vec[3].din = {16'hFFF8, 16'h0007, 16'hFFFA, 16'h0005, 16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cycle(); cycle();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_data", 32'(out_data), 32'd0);
    chk("post_rst_out_col", 32'(out_col), 32'd0);
    chk("post_rst_out_last", 32'(out_last), 32'd0);
    chk("post_rst_row_count", 32'(row_count), 32'd0);

    // Table: single rows, latency and contents
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec[i].din; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("lat_edge1_valid", 32'(out_valid), 32'd0);
      cycle();
      for (int c = 0; c < COL; c++) begin
        chk("tbl_valid", 32'(out_valid), 32'd1);
        chk("tbl_data", 32'(out_data), 32'(vec[i].dout[c]));
        chk("tbl_col", 32'(out_col), 32'(c));
        chk("tbl_last", 32'(out_last), 32'(c == COL - 1));
        cycle();
      end
      chk("tbl_idle", 32'(out_valid), 32'd0);
      chk("tbl_row_count", 32'(row_count), 32'(i + 1));
    end

    // Backpressure: depth+1 rows accepted, then full
    out_ready = 1'b0;
    for (int i = 0; i < DEP + 1; i++) begin
      for (int c = 0; c < COL; c++) r[c] = 16'h1000 * 16'(i + 1) + 16'(c);
      in_valid = 1'b1; in_data = r;
      chk("bp_accept", 32'(in_ready), 32'd1);
      cycle();
    end
    chk("bp_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    cycle();
    chk("bp_full_hold", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < DEP + 1; i++)
      for (int c = 0; c < COL; c++) begin
        chk("bp_nogap", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'(16'h1000 * 16'(i + 1) + 16'(c)));
        cycle();
      end
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_row_count", 32'(row_count), 32'd9);

    // Reset during column 3 of the first of two queued rows
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = vec[3].din; cycle();
    in_data = vec[1].din; cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (out_valid && out_col == 3) found = 1'b1;
      else cycle();
    end
    chk("rst_mid_reach_col3", 32'(found), 32'd1);
    reset = 1'b1;
    cycle();
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_row_count", 32'(row_count), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) chk("rst_remnant", 32'(out_valid), 32'd0);
      cycle();
    end
    chk("rst_quiet", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = vec[0].din; cycle();
    in_valid = 1'b0; cycle();
    for (int c = 0; c < COL; c++) begin
      chk("rst_new_data", 32'(out_data), 32'(vec[0].dout[c]));
      cycle();
    end
    chk("rst_new_row_count", 32'(row_count), 32'd1);

    // Random traffic and stalls; FIFO pointers wrap many times
    for (int k = 0; k < 4000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      for (int c = 0; c < COL; c++) in_data[c*BW +: BW] = BW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || out_valid); k++) cycle();
    chk("rand_drain_q", 32'(exp_q.size()), 32'd0);
    chk("rand_drain_valid", 32'(out_valid), 32'd0);
    ex_rows = m_rows;
    chk("rand_rows_nonzero", 32'(ex_rows != 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
